// File: rtl/vis_centroid_calc.sv
// vis_centroid_calc: per-frame centroid of a binary mask via moment accumulation and a restoring divider
module vis_centroid_calc #(
   parameter int IMG_W    = 1280,
   parameter int IMG_H    = 720,
   parameter int MIN_AREA = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        de,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [23:0] pixel_in,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        centroid_valid,
   output logic        object_found,
   output logic        overrun
);
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t state, state_nxt;
   logic vsync_d, rise, acc_en, ovr_pend, gex, gey;
   logic [10:0] x_pos, y_pos;
   logic [19:0] m00, d, rx, ry, subx, suby;
   logic [30:0] m10, m01, qx, qy;
   logic [20:0] rx_sh, ry_sh;
   logic [4:0] cnt;
   logic unused;
   assign unused = ^{hsync, pixel_in[23:1]};
   assign rise = vsync & ~vsync_d;
   assign acc_en = de & ~vsync & pixel_in[0];
   // one restoring step per cycle: partial remainder gains the next dividend bit
   assign rx_sh = {rx, qx[30]};
   assign ry_sh = {ry, qy[30]};
   assign gex = rx_sh >= {1'b0, d};
   assign gey = ry_sh >= {1'b0, d};
   assign subx = rx_sh[19:0] - d;
   assign suby = ry_sh[19:0] - d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE ? (rise ? DIV : IDLE) :
                  state == DIV  ? (cnt == 5'd30 ? DONE : DIV) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vsync_d <= 1'b0;
         x_pos <= '0;
         y_pos <= '0;
         m00 <= '0;
         m10 <= '0;
         m01 <= '0;
         d <= '0;
         qx <= '0;
         qy <= '0;
         rx <= '0;
         ry <= '0;
         cnt <= '0;
         ovr_pend <= 1'b0;
         overrun <= 1'b0;
         centroid_valid <= 1'b0;
         object_found <= 1'b0;
         x <= '0;
         y <= '0;
      end else begin
         vsync_d <= vsync;
         if (vsync) begin
            x_pos <= '0;
            y_pos <= '0;
         end else if (de) begin
            x_pos <= x_pos == 11'(IMG_W - 1) ? '0 : x_pos + 11'd1;
            if (x_pos == 11'(IMG_W - 1)) y_pos <= y_pos == 11'(IMG_H - 1) ? '0 : y_pos + 11'd1;
         end
         if (rise) begin
            m00 <= '0;
            m10 <= '0;
            m01 <= '0;
         end else if (acc_en) begin
            m00 <= m00 + 20'd1;
            m10 <= m10 + {20'd0, x_pos};
            m01 <= m01 + {20'd0, y_pos};
         end
         // a frame end while busy drops that frame's moments; flagged one cycle later
         ovr_pend <= rise && state != IDLE;
         overrun <= ovr_pend;
         if (state == IDLE && rise) begin
            d <= m00;
            qx <= m10;
            qy <= m01;
            rx <= '0;
            ry <= '0;
            cnt <= '0;
         end else if (state == DIV) begin
            cnt <= cnt + 5'd1;
            qx <= {qx[29:0], gex};
            qy <= {qy[29:0], gey};
            rx <= gex ? subx : rx_sh[19:0];
            ry <= gey ? suby : ry_sh[19:0];
         end
         centroid_valid <= state == DONE;
         if (state == DONE) begin
            object_found <= d >= 20'(MIN_AREA);
            if (d >= 20'(MIN_AREA)) begin
               x <= qx[10:0];
               y <= qy[10:0];
            end
         end
      end
endmodule
